pulse_peak_detector: RTL and testbench
======================================

PULSE_PEAK_DETECTOR -- requirements
Module: pulse_peak_detector

Interface
REQ-001 SHALL have parameter HYST, default 1024, minimum rise/fall in LSB that confirms a peak or trough.
REQ-002 SHALL have parameter MIN_PERIOD, default 50, shortest accepted beat interval in samples.
REQ-003 SHALL have parameter MAX_PERIOD, default 65535, interval in samples after which timeout is flagged.
REQ-004 SHALL have port CLK_Filter  input  1  clock.
REQ-005 SHALL have port rst_n  input  1  reset: asynchronous, active-high.
REQ-006 SHALL have port sample_en  input  1  Filt_In valid this cycle.
REQ-007 SHALL have port Filt_In  input  20  unsigned filtered sample from the FIR stage.
REQ-008 SHALL have port beat_valid  output  1  one-cycle strobe per accepted beat.
REQ-009 SHALL have port beat_period  output  16  samples between the last two accepted peaks.
REQ-010 SHALL have port beat_amplitude  output  20  peak minus preceding trough.
REQ-011 SHALL have port timeout  output  1  no accepted peak within MAX_PERIOD samples.

Function
REQ-012 SHALL update state only on cycles with sample_en=1; otherwise all registers hold and beat_valid=0.
REQ-013 SHALL implement states INIT, SEEK_MAX, SEEK_MIN.
REQ-014 INIT: first sample loads cur_max=cur_min=sample -> SEEK_MAX.
REQ-015 SEEK_MAX: sample>cur_max -> cur_max=sample, cnt_at_max=interval count; cur_max-sample>=HYST -> peak confirmed, cur_min=sample -> SEEK_MIN.
REQ-016 SEEK_MIN: sample<cur_min -> cur_min=sample; sample-cur_min>=HYST -> cur_max=sample, cnt_at_max=interval count -> SEEK_MAX.
REQ-017 SHALL keep a 16-bit interval counter, +1 per enabled sample, saturating at MAX_PERIOD.
REQ-018 On peak confirmation with a previous accepted peak and cnt_at_max>=MIN_PERIOD: beat_period=cnt_at_max, beat_amplitude=cur_max-trough, beat_valid=1, counter rebased to counter-cnt_at_max.
REQ-019 On peak confirmation with no previous accepted peak: peak recorded as reference, counter rebased, no beat_valid.
REQ-020 On peak with cnt_at_max<MIN_PERIOD: peak rejected, no beat_valid, counter not rebased; FSM still -> SEEK_MIN.
REQ-021 beat_valid SHALL assert on the cycle after the sample_en cycle carrying the confirming sample, for exactly one cycle.
REQ-022 beat_period and beat_amplitude SHALL hold between beats.
REQ-023 Counter reaching MAX_PERIOD SHALL set timeout=1 and clear the previous-peak flag; timeout clears on the next confirmed (reference) peak.
REQ-024 Confirmation and saturation on the same sample: confirmation takes priority, timeout not set.
REQ-025 Threshold compares SHALL use 21-bit unsigned arithmetic; no wrap-around at 20'hFFFFF or 0.
REQ-026 Equality (difference exactly HYST) SHALL confirm.

Reset
REQ-027 rst_n=1 SHALL asynchronously force state=INIT, counters, cur_max, cur_min, previous-peak flag to 0.
REQ-028 Reset values: beat_valid=0, beat_period=0, beat_amplitude=0, timeout=0.
REQ-029 Reset mid-beat SHALL discard all partial measurement; first post-reset peak is a reference only.

Structure
REQ-030 Package pulse_pkg SHALL hold DATA_W=20, PERIOD_W=16 and the state enumeration.
REQ-031 Sub-module sat_counter (enable, load, saturate at MAX_PERIOD) SHALL implement the interval counter.

Verification (HYST=1024, MIN_PERIOD=50, MAX_PERIOD=65535)
REQ-032 rst_n pulsed during SEEK_MIN -> all outputs 0 immediately, next sample enters INIT.
REQ-033 Triangle 0..40000, period 100 samples, sample_en=1 every cycle -> from second peak, beat_valid every 100 cycles, beat_period=100, beat_amplitude=40000.
REQ-034 Flat 30000 with +/-500 ripple -> no beat_valid, state never leaves SEEK_MAX/SEEK_MIN hysteresis.
REQ-035 Peaks at samples 0, 30, 100 (each with >=HYST swing) -> peak at 30 rejected; beat at 100 with beat_period=100.
REQ-036 Constant input for 65535 samples -> timeout=1; next peak no beat_valid, timeout=0; following peak beat_valid.
REQ-037 sample_en every 4th cycle, triangle period 100 samples -> beat_period=100 (samples, not cycles).

Source files
------------

// File: rtl/pulse_pkg.sv
// Shared widths, FSM states and threshold helper for the pulse peak detector.
package pulse_pkg;

  localparam int DATA_W   = 20;
  localparam int PERIOD_W = 16;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_SEEK_MAX,
    ST_SEEK_MIN
  } state_e;

  // hi - lo >= thr, evaluated one bit wider so a negative difference never wraps
  function automatic logic diff_ge(
    input logic [DATA_W-1:0] hi,
    input logic [DATA_W-1:0] lo,
    input logic [DATA_W:0]   thr
  );
    logic [DATA_W:0] d;
    d = {1'b0, hi} - {1'b0, lo};
    return !d[DATA_W] && (d >= thr);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Sample interval counter: counts enabled samples, loadable, saturates at MAX.
module sat_counter
  import pulse_pkg::*;
#(
  parameter logic [PERIOD_W-1:0] MAX = '1
) (
  input  logic                CLK_Filter,
  input  logic                rst_n,
  input  logic                en_i,
  input  logic                load_i,
  input  logic [PERIOD_W:0]   load_val_i,
  output logic [PERIOD_W-1:0] cnt_o,
  output logic                sat_o
);

  logic [PERIOD_W-1:0] cnt_q;
  logic [PERIOD_W-1:0] cnt_d;
  logic [PERIOD_W:0]   raw;

  always_comb begin
    raw   = load_i ? load_val_i
                   : {1'b0, cnt_q} + (PERIOD_W+1)'(1);
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = (raw >= {1'b0, MAX}) ? MAX : raw[PERIOD_W-1:0];
    end
  end

  always_ff @(posedge CLK_Filter or posedge rst_n) begin
    if (rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign sat_o = en_i && !load_i && (cnt_d == MAX);

endmodule

// File: rtl/pulse_peak_detector.sv
// Hysteresis peak/trough tracker producing beat period and amplitude strobes.
module pulse_peak_detector
  import pulse_pkg::*;
#(
  parameter int unsigned HYST       = 1024,
  parameter int unsigned MIN_PERIOD = 50,
  parameter int unsigned MAX_PERIOD = 65535
) (
  input  logic                CLK_Filter,
  input  logic                rst_n,
  input  logic                sample_en,
  input  logic [DATA_W-1:0]   Filt_In,
  output logic                beat_valid,
  output logic [PERIOD_W-1:0] beat_period,
  output logic [DATA_W-1:0]   beat_amplitude,
  output logic                timeout
);

  localparam logic [DATA_W:0]     HYST_T = HYST[DATA_W:0];
  localparam logic [PERIOD_W-1:0] MIN_P  = MIN_PERIOD[PERIOD_W-1:0];
  localparam logic [PERIOD_W-1:0] MAX_P  = MAX_PERIOD[PERIOD_W-1:0];

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   cur_max_q, cur_max_d;
  logic [DATA_W-1:0]   cur_min_q, cur_min_d;
  logic [PERIOD_W-1:0] at_max_q, at_max_d;
  logic                prev_q, prev_d;
  logic                valid_q, valid_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [DATA_W-1:0]   amp_q, amp_d;
  logic                tmo_q, tmo_d;

  logic                conf;
  logic                rebase;
  logic                cnt_sat;
  logic [PERIOD_W-1:0] cnt;
  logic [PERIOD_W:0]   rebase_val;

  // next sample's index measured from the peak just confirmed
  assign rebase_val = {1'b0, cnt} - {1'b0, at_max_q}
                    + (PERIOD_W+1)'(1);

  sat_counter #(
    .MAX (MAX_P)
  ) u_cnt (
    .CLK_Filter (CLK_Filter),
    .rst_n      (rst_n),
    .en_i       (sample_en),
    .load_i     (rebase),
    .load_val_i (rebase_val),
    .cnt_o      (cnt),
    .sat_o      (cnt_sat)
  );

  always_comb begin
    state_d   = state_q;
    cur_max_d = cur_max_q;
    cur_min_d = cur_min_q;
    at_max_d  = at_max_q;
    prev_d    = prev_q;
    valid_d   = 1'b0;
    period_d  = period_q;
    amp_d     = amp_q;
    tmo_d     = tmo_q;
    conf      = 1'b0;
    rebase    = 1'b0;
    if (sample_en) begin
      unique case (state_q)
        ST_INIT: begin
          cur_max_d = Filt_In;
          cur_min_d = Filt_In;
          at_max_d  = cnt;
          state_d   = ST_SEEK_MAX;
        end
        ST_SEEK_MAX: begin
          if (Filt_In > cur_max_q) begin
            cur_max_d = Filt_In;
            at_max_d  = cnt;
          end else if (diff_ge(cur_max_q, Filt_In, HYST_T)) begin
            conf      = 1'b1;
            cur_min_d = Filt_In;
            state_d   = ST_SEEK_MIN;
            if (!prev_q) begin
              prev_d = 1'b1;
              rebase = 1'b1;
              tmo_d  = 1'b0;
            end else if (at_max_q >= MIN_P) begin
              valid_d  = 1'b1;
              period_d = at_max_q;
              amp_d    = cur_max_q - cur_min_q;
              rebase   = 1'b1;
            end
          end
        end
        ST_SEEK_MIN: begin
          if (Filt_In < cur_min_q) begin
            cur_min_d = Filt_In;
          end else if (diff_ge(Filt_In, cur_min_q, HYST_T)) begin
            cur_max_d = Filt_In;
            at_max_d  = cnt;
            state_d   = ST_SEEK_MAX;
          end
        end
        default: state_d = ST_INIT;
      endcase
      if (cnt_sat && !conf) begin
        tmo_d  = 1'b1;
        prev_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK_Filter or posedge rst_n) begin
    if (rst_n) begin
      state_q   <= ST_INIT;
      cur_max_q <= '0;
      cur_min_q <= '0;
      at_max_q  <= '0;
      prev_q    <= 1'b0;
      valid_q   <= 1'b0;
      period_q  <= '0;
      amp_q     <= '0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_max_q <= cur_max_d;
      cur_min_q <= cur_min_d;
      at_max_q  <= at_max_d;
      prev_q    <= prev_d;
      valid_q   <= valid_d;
      period_q  <= period_d;
      amp_q     <= amp_d;
      tmo_q     <= tmo_d;
    end
  end

  assign beat_valid     = valid_q;
  assign beat_period    = period_q;
  assign beat_amplitude = amp_q;
  assign timeout        = tmo_q;

endmodule

// File: tb/tb_pulse_peak_detector.sv
// Directed bench for pulse_peak_detector with hand-computed beat expectations.
module tb_pulse_peak_detector;

  logic        CLK_Filter = 1'b0;
  logic        rst_n = 1'b1;
  logic        sample_en = 1'b0;
  logic [19:0] Filt_In = '0;
  logic        beat_valid;
  logic [15:0] beat_period;
  logic [19:0] beat_amplitude;
  logic        timeout;

  int total = 0;
  int bad   = 0;

  pulse_peak_detector #(
    .HYST       (1024),
    .MIN_PERIOD (50),
    .MAX_PERIOD (65535)
  ) dut (
    .CLK_Filter     (CLK_Filter),
    .rst_n          (rst_n),
    .sample_en      (sample_en),
    .Filt_In        (Filt_In),
    .beat_valid     (beat_valid),
    .beat_period    (beat_period),
    .beat_amplitude (beat_amplitude),
    .timeout        (timeout)
  );

  always #5 CLK_Filter = ~CLK_Filter;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    sample_en = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(posedge CLK_Filter);
    #1 rst_n = 1'b0;
    @(posedge CLK_Filter);
    #1;
  endtask

  task automatic send(input logic [19:0] v, input logic exp_bv,
                      input int idle);
    sample_en = 1'b1;
    Filt_In = v;
    @(posedge CLK_Filter);
    #1 sample_en = 1'b0;
    chk("beat_valid", 32'(beat_valid), 32'(exp_bv));
    for (int i = 0; i < idle; i++) begin
      @(posedge CLK_Filter);
      #1 chk("idle_beat_valid", 32'(beat_valid), 0);
    end
  endtask

  function automatic logic [19:0] tri_wave(input int k);
    int p;
    p = k % 100;
    return (p <= 50) ? 20'(800 * p) : 20'(800 * (100 - p));
  endfunction

  initial begin
    int nbeat;

    // reset values
    do_reset();
    chk("rst_valid", 32'(beat_valid), 0);
    chk("rst_period", 32'(beat_period), 0);
    chk("rst_amp", 32'(beat_amplitude), 0);
    chk("rst_timeout", 32'(timeout), 0);

    // triangle, sample_en every cycle: beats confirmed at samples 152, 252, 352
    nbeat = 0;
    for (int k = 0; k <= 360; k++) begin
      logic eb;
      eb = (k >= 152) && (k % 100 == 52);
      send(tri_wave(k), eb, 0);
      if (eb) begin
        nbeat++;
        chk("tri_period", 32'(beat_period), 100);
        chk("tri_amp", 32'(beat_amplitude), 40000);
      end
    end
    chk("tri_nbeat", 32'(nbeat), 3);
    chk("tri_hold_period", 32'(beat_period), 100);
    chk("tri_hold_amp", 32'(beat_amplitude), 40000);

    // asynchronous reset while in SEEK_MIN
    #3 rst_n = 1'b1;
    #1;
    chk("arst_valid", 32'(beat_valid), 0);
    chk("arst_period", 32'(beat_period), 0);
    chk("arst_amp", 32'(beat_amplitude), 0);
    chk("arst_timeout", 32'(timeout), 0);
    #1 rst_n = 1'b0;

    // sample_en every 4th cycle: period measured in samples
    do_reset();
    for (int k = 0; k <= 260; k++) begin
      logic eb;
      eb = (k >= 152) && (k % 100 == 52);
      send(tri_wave(k), eb, 3);
      if (eb) begin
        chk("sp4_period", 32'(beat_period), 100);
        chk("sp4_amp", 32'(beat_amplitude), 40000);
      end
    end

    // ripple below hysteresis never produces a beat
    do_reset();
    for (int k = 0; k < 200; k++) begin
      send((k % 2 == 1) ? 20'd30500 : 20'd29500, 1'b0, 0);
    end
    chk("flat_timeout", 32'(timeout), 0);

    // peaks at 0, 30 (too soon, rejected), 100
    do_reset();
    send(20'd30000, 1'b0, 0);
    for (int k = 1; k < 30; k++) send(20'd20000, 1'b0, 0);
    send(20'd30000, 1'b0, 0);
    send(20'd20000, 1'b0, 0);
    for (int k = 32; k < 100; k++) send(20'd10000, 1'b0, 0);
    send(20'd30000, 1'b0, 0);
    send(20'd20000, 1'b1, 0);
    chk("rej_period", 32'(beat_period), 100);
    chk("rej_amp", 32'(beat_amplitude), 20000);

    // swing of exactly HYST confirms, HYST-1 does not
    do_reset();
    send(20'd5000, 1'b0, 0);
    for (int k = 1; k < 30; k++) send(20'd3976, 1'b0, 0);
    send(20'd4999, 1'b0, 0);
    for (int k = 31; k < 60; k++) send(20'd3976, 1'b0, 0);
    send(20'd5000, 1'b0, 0);
    send(20'd3976, 1'b1, 0);
    chk("eq_period", 32'(beat_period), 60);
    chk("eq_amp", 32'(beat_amplitude), 1024);

    // full-scale swings: no wrap at 0 / 20'hFFFFF
    do_reset();
    send(20'd0, 1'b0, 0);
    send(20'hFFFFF, 1'b0, 0);
    for (int k = 2; k < 60; k++) send(20'd0, 1'b0, 0);
    send(20'hFFFFF, 1'b0, 0);
    send(20'd0, 1'b1, 0);
    chk("fs_period", 32'(beat_period), 59);
    chk("fs_amp", 32'(beat_amplitude), 32'hFFFFF);

    // constant input saturates the interval counter
    do_reset();
    for (int k = 0; k < 65534; k++) send(20'd10000, 1'b0, 0);
    chk("tmo_before", 32'(timeout), 0);
    send(20'd10000, 1'b0, 0);
    chk("tmo_set", 32'(timeout), 1);
    send(20'd15000, 1'b0, 0);
    send(20'd20000, 1'b0, 0);
    chk("tmo_held", 32'(timeout), 1);
    send(20'd18000, 1'b0, 0);
    chk("tmo_clear", 32'(timeout), 0);
    for (int k = 0; k < 58; k++) send(20'd10000, 1'b0, 0);
    send(20'd20000, 1'b0, 0);
    send(20'd18000, 1'b1, 0);
    chk("tmo_amp", 32'(beat_amplitude), 10000);
    chk("tmo_after", 32'(timeout), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
